// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 7-segment driver: shadowed BCD/dp inputs, prescaled digit scan, registered outputs.
// Leading-zero blanking is compiled in only when the macro SEVEN_SEG_LZB_EN is defined.
module seven_seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] bcd,
    input  logic [DIGITS-1:0]   dp_in,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   dps_q, dps_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                fd_q, fd_d;
    logic                advance;
    logic [3:0]          code;

    function automatic logic [6:0] encode(input logic [3:0] c);
        case (c)
            4'd0:    encode = 7'h3F;
            4'd1:    encode = 7'h06;
            4'd2:    encode = 7'h5B;
            4'd3:    encode = 7'h4F;
            4'd4:    encode = 7'h66;
            4'd5:    encode = 7'h6D;
            4'd6:    encode = 7'h7D;
            4'd7:    encode = 7'h07;
            4'd8:    encode = 7'h7F;
            4'd9:    encode = 7'h6F;
            default: encode = 7'h40;
        endcase
    endfunction

`ifdef SEVEN_SEG_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              zero_run;
    logic              lz_blank;

    // lz[i] is set when digit i and every digit above it hold code 0; digit 0 is never blanked.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (bcd_q[4*i +: 4] == 4'd0);
            lz[i]    = zero_run;
        end
        lz_blank = lz[idx_q];
    end
`endif

    always_comb begin
        advance = en && (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (en) begin
            presc_d = advance ? '0 : presc_q + 1'b1;
        end
        idx_d = idx_q;
        if (advance) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        fd_d  = advance && (idx_q == IDX_LAST);
        bcd_d = load ? bcd : bcd_q;
        dps_d = load ? dp_in : dps_q;
        code  = bcd_q[4*idx_q +: 4];

        // Outputs reflect the current index and shadow, so they appear one cycle later.
        an_d  = '0;
        seg_d = '0;
        dp_d  = 1'b0;
        if (en) begin
            an_d  = DIGITS'(1) << idx_q;
            dp_d  = dps_q[idx_q];
            seg_d = encode(code);
`ifdef SEVEN_SEG_LZB_EN
            if (lz_blank) begin
                seg_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            bcd_q   <= '0;
            dps_q   <= '0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            an_q    <= '0;
            fd_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            dps_q   <= dps_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            fd_q    <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (DIGITS=4, SCAN_DIV=3): constant vectors,
// directed corner sequences and randomized traffic against a counting reference model.
module tb_seven_seg_scan_driver;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 3;
    localparam int FRAME    = DIGITS * SCAN_DIV;
`ifdef SEVEN_SEG_LZB_EN
    localparam logic [6:0] LZ_SEG = 7'h00;
`else
    localparam logic [6:0] LZ_SEG = 7'h3F;
`endif

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .bcd(bcd), .dp_in(dp_in),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    // Reference model: number of enabled cycles since reset plus the latched shadow values.
    int          m_count;
    int unsigned m_shadow;
    int unsigned m_dps;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_fd;

    function automatic logic [6:0] glyph(input int unsigned c);
        case (c)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  default: return 7'h40;
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input int i);
        int unsigned upper;
        upper = m_shadow >> (4 * i);
`ifdef SEVEN_SEG_LZB_EN
        if (i > 0 && upper == 0) return 7'h00;
`endif
        return glyph(upper & 15);
    endfunction

    task automatic step(input logic r, input logic e, input logic l,
                        input logic [15:0] b, input logic [3:0] d);
        int idx;
        rst = r; en = e; load = l; bcd = b; dp_in = d;
        idx = (m_count / SCAN_DIV) % DIGITS;
        if (r || !e) begin
            e_an = 4'd0; e_seg = 7'd0; e_dp = 1'b0; e_fd = 1'b0;
        end else begin
            e_an  = 4'(1 << idx);
            e_seg = ref_seg(idx);
            e_dp  = 1'((m_dps >> idx) & 1);
            e_fd  = ((m_count + 1) % FRAME) == 0;
        end
        @(posedge clk);
        if (r) begin
            m_count = 0; m_shadow = 0; m_dps = 0;
        end else begin
            if (l) begin
                m_shadow = b; m_dps = d;
            end
            if (e) m_count++;
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] x_an, input logic [6:0] x_seg,
                           input logic x_dp, input logic x_fd);
        chk({tag, ".an"}, 32'(an), 32'(x_an));
        chk({tag, ".seg"}, 32'(seg), 32'(x_seg));
        chk({tag, ".dp"}, 32'(dp), 32'(x_dp));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(x_fd));
    endtask

    task automatic chk_model(input string tag);
        chk_out(tag, e_an, e_seg, e_dp, e_fd);
    endtask

    typedef struct {
        logic        r, e, l;
        logic [15:0] b;
        logic [3:0]  d;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fd;
    } vec_t;

    function automatic vec_t mkv(input logic r, input logic e, input logic l, input logic [15:0] b,
                                 input logic [3:0] d, input logic [3:0] x_an, input logic [6:0] x_seg,
                                 input logic x_dp, input logic x_fd);
        vec_t v;
        v.r = r; v.e = e; v.l = l; v.b = b; v.d = d;
        v.an = x_an; v.seg = x_seg; v.dp = x_dp; v.fd = x_fd;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int fd_count, first, last, gap, n;
        logic [15:0] rb;
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd = '0; dp_in = '0;
        m_count = 0; m_shadow = 0; m_dps = 0;

        // Basic scan of 0x1234 with dp on digit 2.
        tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 7'h00, 1'b0, 1'b0));
        tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0100, 4'b0001, 7'h3F, 1'b0, 1'b0));
        for (int k = 2; k <= 13; k++) begin
            logic [3:0] xa;
            logic [6:0] xs;
            int di;
            di = ((k - 1) / SCAN_DIV) % DIGITS;
            xa = 4'(1 << di);
            case (di)
                0: xs = 7'h66;
                1: xs = 7'h4F;
                2: xs = 7'h5B;
                default: xs = 7'h06;
            endcase
            tbl.push_back(mkv(1'b0, 1'b1, 1'b0, 16'h1234, 4'b0100, xa, xs, di == 2, k == 12));
        end
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].b, tbl[i].d);
            chk_out($sformatf("vec%0d", i), tbl[i].an, tbl[i].seg, tbl[i].dp, tbl[i].fd);
        end

        // Dash and (optional) leading-zero blanking with 0x00A7.
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 16'h00A7, 4'h0);
        for (int k = 2; k <= 13; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h00A7, 4'h0);
            chk_model($sformatf("a7_cyc%0d", k));
            if (k == 2)  chk("a7_digit0", 32'(seg), 32'(7'h07));
            if (k == 5)  chk("a7_digit1", 32'(seg), 32'(7'h40));
            if (k == 8)  chk("a7_digit2", 32'(seg), 32'(LZ_SEG));
            if (k == 11) chk("a7_digit3", 32'(seg), 32'(LZ_SEG));
        end

        // Two full frames: exactly two single-cycle pulses, 12 cycles apart.
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        fd_count = 0; first = -1; last = -1; gap = 0;
        for (int k = 1; k <= 26; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
            chk_model($sformatf("frame_cyc%0d", k));
            if (frame_done) begin
                if (last >= 0) gap = k - last;
                if (first < 0) first = k;
                last = k;
                fd_count++;
            end
        end
        chk("frame_done_count", 32'(fd_count), 32'd2);
        chk("frame_done_first", 32'(first), 32'd12);
        chk("frame_done_gap", 32'(gap), 32'd12);

        // Enable dropped mid-digit: dark output, then resume with held prescaler.
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 16'h5678, 4'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 16'h5678, 4'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 16'h5678, 4'h0);
            chk_out($sformatf("dark%0d", k), 4'b0000, 7'h00, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 16'h5678, 4'h0);
        chk_out("resume1", 4'b0010, 7'h07, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h5678, 4'h0);
        chk_out("resume2", 4'b0010, 7'h07, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h5678, 4'h0);
        chk_out("resume3", 4'b0100, 7'h7D, 1'b0, 1'b0);

        // Load coincident with an index advance.
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 16'h9999, 4'h0);
        chk_out("load_adv0", 4'b0001, 7'h3F, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h9999, 4'h0);
        chk_out("load_adv1", 4'b0010, 7'h6F, 1'b0, 1'b0);

        // Reset asserted at idx=2 overrides en/load.
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0100);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0, 16'h1234, 4'b0100);
        chk_out("pre_rst_idx2", 4'b0100, 7'h5B, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF);
        chk_out("mid_rst", 4'b0000, 7'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        chk_out("post_rst", 4'b0001, 7'h3F, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            n  = $urandom_range(0, 4);
            rb = 16'($urandom) >> (4 * n);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 7) == 0, rb, 4'($urandom));
            chk_model($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
